// File: rtl/ddls_pkg.sv
// Shared types and defaults for the delayed dual-lockstep sequencer and its comparator.
package ddls_pkg;

  localparam int unsigned DFLT_BUFFERSIZE = 4;
  localparam int unsigned DFLT_CMP_WIDTH  = 181;
  localparam int unsigned SEL_MAX         = 32;
  localparam int unsigned SEL_IDX_W       = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CHECK = 2'd2,
    HALT  = 2'd3
  } state_t;

  // Callers truncate the result to their own delay-line depth.
  function automatic logic [SEL_MAX-1:0] idx_to_onehot(input logic [SEL_IDX_W-1:0] idx);
    logic [SEL_MAX-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/ddls_if.sv
// Configuration, comparator and status bundle between software/comparator (master) and ddls_ctrl (slave).
interface ddls_if
  import ddls_pkg::*;
#(
  parameter int unsigned BUFFERSIZE = DFLT_BUFFERSIZE,
  parameter int unsigned IDX_W      = 2,
  parameter int unsigned CMP_WIDTH  = DFLT_CMP_WIDTH,
  parameter int unsigned CNT_W      = 16
);

  logic                  cfg_enable;
  logic [IDX_W-1:0]      cfg_delay;
  logic [CNT_W-1:0]      cfg_thresh;
  logic                  err_clr;
  logic [BUFFERSIZE-1:0] delay_sel;
  logic                  start;
  logic                  cmp_flag;
  logic [CMP_WIDTH-1:0]  cmp_result;
  logic                  busy;
  logic                  err_irq;
  logic                  cfg_err;
  logic [CNT_W-1:0]      err_count;
  logic [CNT_W-1:0]      chk_cycles;
  logic [CMP_WIDTH-1:0]  first_syn;
  logic [CNT_W-1:0]      first_cyc;

  modport master (
    output cfg_enable, cfg_delay, cfg_thresh, err_clr, cmp_flag, cmp_result,
    input  delay_sel, start, busy, err_irq, cfg_err, err_count, chk_cycles, first_syn, first_cyc
  );

  modport slave (
    input  cfg_enable, cfg_delay, cfg_thresh, err_clr, cmp_flag, cmp_result,
    output delay_sel, start, busy, err_irq, cfg_err, err_count, chk_cycles, first_syn, first_cyc
  );

endinterface

// File: rtl/ddls_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module ddls_sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/ddls_ctrl.sv
// Lockstep sequencer: programs the comparator delay, waits out pipeline fill, then
// counts mismatches, captures the first syndrome and halts at a threshold.
module ddls_ctrl
  import ddls_pkg::*;
#(
  parameter int unsigned BUFFERSIZE = DFLT_BUFFERSIZE,
  parameter int unsigned IDX_W      = 2,
  parameter int unsigned CMP_WIDTH  = DFLT_CMP_WIDTH,
  parameter int unsigned CNT_W      = 16
) (
  input logic   clk,
  input logic   resetb,
  ddls_if.slave bus
);

  localparam int unsigned      FILL_W  = IDX_W + 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(BUFFERSIZE - 1);

  state_t                state_q, state_n;
  logic [FILL_W-1:0]     fill_q, fill_n;
  logic [BUFFERSIZE-1:0] delay_sel_q, delay_sel_n;
  logic                  start_q, start_n, start_d_q;
  logic                  busy_q, busy_n;
  logic                  irq_q, irq_n;
  logic                  cfg_err_q, cfg_err_n;
  logic [CMP_WIDTH-1:0]  syn_q, syn_n;
  logic [CNT_W-1:0]      cyc_q, cyc_n;
  logic [CNT_W-1:0]      err_count, chk_cycles;

  logic                  clamp_c;
  logic [IDX_W-1:0]      idx_c;
  logic [CNT_W-1:0]      thresh_c;
  logic [CNT_W-1:0]      err_post_c;
  logic                  hit_c;
  logic                  chk_inc_c;

  assign clamp_c    = (bus.cfg_delay > IDX_MAX);
  assign idx_c      = clamp_c ? IDX_MAX : bus.cfg_delay;
  assign thresh_c   = (bus.cfg_thresh == '0) ? CNT_W'(1) : bus.cfg_thresh;
  assign err_post_c = (&err_count) ? err_count : err_count + CNT_W'(1);
  // Comparator flag is valid one cycle after start; a clear in the same cycle drops it.
  assign hit_c      = start_d_q && bus.cmp_flag && (state_q != HALT) && !bus.err_clr;
  assign chk_inc_c  = (state_q == CHECK);

  ddls_sat_cnt #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (resetb),
    .inc   (hit_c),
    .clr   (bus.err_clr),
    .count (err_count)
  );

  ddls_sat_cnt #(.W(CNT_W)) u_chk_cnt (
    .clk   (clk),
    .rst   (resetb),
    .inc   (chk_inc_c),
    .clr   (bus.err_clr),
    .count (chk_cycles)
  );

  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) begin
      state_q     <= IDLE;
      fill_q      <= '0;
      delay_sel_q <= BUFFERSIZE'(1);
      start_q     <= 1'b0;
      start_d_q   <= 1'b0;
      busy_q      <= 1'b0;
      irq_q       <= 1'b0;
      cfg_err_q   <= 1'b0;
      syn_q       <= '0;
      cyc_q       <= '0;
    end else begin
      state_q     <= state_n;
      fill_q      <= fill_n;
      delay_sel_q <= delay_sel_n;
      start_q     <= start_n;
      start_d_q   <= start_q;
      busy_q      <= busy_n;
      irq_q       <= irq_n;
      cfg_err_q   <= cfg_err_n;
      syn_q       <= syn_n;
      cyc_q       <= cyc_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    fill_n      = fill_q;
    delay_sel_n = delay_sel_q;
    irq_n       = irq_q;
    cfg_err_n   = cfg_err_q;
    syn_n       = syn_q;
    cyc_n       = cyc_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cfg_enable) begin
          state_n     = FILL;
          delay_sel_n = BUFFERSIZE'(idx_to_onehot(SEL_IDX_W'(idx_c)));
          fill_n      = FILL_W'(idx_c) + FILL_W'(1);
          if (clamp_c) cfg_err_n = 1'b1;
        end
      end
      FILL: begin
        if (!bus.cfg_enable) begin
          state_n = IDLE;
        end else begin
          fill_n = fill_q - FILL_W'(1);
          if (fill_q == FILL_W'(1)) state_n = CHECK;
        end
      end
      CHECK: begin
        if (hit_c && (err_post_c >= thresh_c)) state_n = HALT;
        else if (!bus.cfg_enable)              state_n = IDLE;
      end
      HALT: begin
        if (bus.err_clr) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (hit_c) begin
      if (err_count == '0) begin
        syn_n = bus.cmp_result;
        cyc_n = chk_cycles - CNT_W'(1);
      end
      if (err_post_c >= thresh_c) irq_n = 1'b1;
    end

    if (bus.err_clr) begin
      irq_n     = 1'b0;
      cfg_err_n = 1'b0;
      syn_n     = '0;
      cyc_n     = '0;
    end

    start_n = (state_n == CHECK);
    busy_n  = (state_n == FILL) || (state_n == CHECK);
  end

  assign bus.delay_sel  = delay_sel_q;
  assign bus.start      = start_q;
  assign bus.busy       = busy_q;
  assign bus.err_irq    = irq_q;
  assign bus.cfg_err    = cfg_err_q;
  assign bus.err_count  = err_count;
  assign bus.chk_cycles = chk_cycles;
  assign bus.first_syn  = syn_q;
  assign bus.first_cyc  = cyc_q;

endmodule
